shift_rows: RTL and testbench



---
 rtl/shift_rows_pkg.sv | 23 ++
 rtl/shift_rows_perm.sv | 36 +++
 rtl/shift_rows.sv | 65 ++++++
 tb/tb_shift_rows.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shift_rows_pkg.sv
// shift_rows_pkg: shared types and index helper for the AES ShiftRows stage.
//   byte_t  : one state byte.
//   rot_idx : source column of byte r in output column c, for a state of
//             n columns, forward (inv = 0) or inverse (inv = 1) rotation.
//             Called only with elaboration-time constants, so it folds
//             away and no runtime modulo hardware is built.
package shift_rows_pkg;

  typedef logic [7:0] byte_t;

  function automatic int rot_idx(input int c, input int r, input int n,
                                 input logic inv);
    int shift;
    // Rows can outnumber columns for wide words; reduce the shift first
    // so the inverse subtraction can never go negative.
    shift = r % n;
    if (inv)
      return (c - shift + n) % n;
    else
      return (c + shift) % n;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: purely combinational ShiftRows byte permutation.
//   Row r is byte r counted from the MSB of each column word.
//   Forward: row r rotates left by r columns. Inverse: row r rotates right.
// Ports:
//   vect_in  [vecSize] x regSize  input state
//   inv                           1 = inverse mapping
//   vect_out [vecSize] x regSize  permuted state (combinational)
module shift_rows_perm
  import shift_rows_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [regSize-1:0] vect_in  [vecSize-1:0],
  input  logic               inv,
  output logic [regSize-1:0] vect_out [vecSize-1:0]
);

  localparam int ROWS = regSize / 8;

  for (genvar c = 0; c < vecSize; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int FWD_SRC = rot_idx(c, r, vecSize, 1'b0);
      localparam int INV_SRC = rot_idx(c, r, vecSize, 1'b1);
      localparam int HI      = regSize - 1 - 8 * r;

      byte_t fwd_b;
      byte_t inv_b;

      assign fwd_b = vect_in[FWD_SRC][HI -: 8];
      assign inv_b = vect_in[INV_SRC][HI -: 8];
      assign vect_out[c][HI -: 8] = inv ? inv_b : fwd_b;
    end
  end

endmodule

// File: rtl/shift_rows.sv
// shift_rows: registered AES ShiftRows stage between SubBytes and MixColumns.
//   One result per cycle, 1-cycle latency, no backpressure. When no valid
//   input arrives the output state holds and out_valid drops.
//   Optional feature macro: SHIFT_ROWS_INV_EN adds the 'inv' port which
//   selects InvShiftRows per transaction; without it only the forward
//   mapping exists.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset (clears output and valid)
//   in_valid  vect_in valid this cycle
//   vect_in   [vecSize] x regSize input state
//   inv       (SHIFT_ROWS_INV_EN only) 1 = inverse mapping
//   out_valid vect_out holds a new result
//   vect_out  [vecSize] x regSize registered permuted state
// regSize must be a multiple of 8.
module shift_rows
  import shift_rows_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [regSize-1:0] vect_in  [vecSize-1:0],
`ifdef SHIFT_ROWS_INV_EN
  input  logic               inv,
`endif
  output logic               out_valid,
  output logic [regSize-1:0] vect_out [vecSize-1:0]
);

  logic               inv_sel;
  logic [regSize-1:0] perm_p0 [vecSize-1:0];

`ifdef SHIFT_ROWS_INV_EN
  assign inv_sel = inv;
`else
  assign inv_sel = 1'b0;
`endif

  // Stage p0: combinational permutation of the incoming state
  shift_rows_perm #(
    .regSize (regSize),
    .vecSize (vecSize)
  ) u_perm (
    .vect_in  (vect_in),
    .inv      (inv_sel),
    .vect_out (perm_p0)
  );

  // Stage p0 -> output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int c = 0; c < vecSize; c++)
        vect_out[c] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        vect_out <= perm_p0;
    end
  end

endmodule

// File: tb/tb_shift_rows.sv
module tb_shift_rows;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] vect_in  [3:0];
  logic        out_valid;
  logic [31:0] vect_out [3:0];
`ifdef SHIFT_ROWS_INV_EN
  logic        inv;
`endif

  int n_cmp;
  int n_bad;

  shift_rows #(
    .regSize (32),
    .vecSize (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .vect_in   (vect_in),
`ifdef SHIFT_ROWS_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .vect_out  (vect_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word 0 sits in the MSBs of the packed 128-bit form.
  typedef struct {
    string        name;
    logic [127:0] in_v;
    logic [127:0] exp_v;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [127:0] out_packed();
    logic [127:0] v;
    for (int c = 0; c < 4; c++)
      v[127-32*c -: 32] = vect_out[c];
    return v;
  endfunction

  task automatic drive(input logic vld, input logic [127:0] v);
    in_valid = vld;
    for (int c = 0; c < 4; c++)
      vect_in[c] = v[127-32*c -: 32];
  endtask

  task automatic check_vec(input string name, input logic [127:0] exp_v);
    logic [127:0] act;
    act = out_packed();
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: vect_out got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp_b);
    n_cmp++;
    if (act !== exp_b) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp_b);
    end
  endtask

  logic [127:0] last_exp;

  initial begin
    n_cmp = 0;
    n_bad = 0;

    tbl[0] = '{"aes_fwd",
               {32'h63637c7c, 32'h7b7bc5c5, 32'h7676c0c0, 32'h7575d2d2},
               {32'h637bc0d2, 32'h7b76d27c, 32'h76757cc5, 32'h7563c5c0}};
    tbl[1] = '{"invariant",
               {32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304},
               {32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304}};
    tbl[2] = '{"index_bytes",
               {32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233},
               {32'h00112233, 32'h10213203, 32'h20310213, 32'h30011223}};
    tbl[3] = '{"single_col",
               {32'hffeeddcc, 32'h00000000, 32'h00000000, 32'h00000000},
               {32'hff000000, 32'h000000cc, 32'h0000dd00, 32'h00ee0000}};
    tbl[4] = '{"aes_fwd_again",
               {32'h63637c7c, 32'h7b7bc5c5, 32'h7676c0c0, 32'h7575d2d2},
               {32'h637bc0d2, 32'h7b76d27c, 32'h76757cc5, 32'h7563c5c0}};

    rst = 1'b1;
    drive(1'b0, '0);
`ifdef SHIFT_ROWS_INV_EN
    inv = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_vect", '0);
    check_bit("reset_valid", out_valid, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream through the whole table: one result per cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tbl[i].in_v);
      @(posedge clk);
      #1;
      check_vec(tbl[i].name, tbl[i].exp_v);
      check_bit({tbl[i].name, "_valid"}, out_valid, 1'b1);
      last_exp = tbl[i].exp_v;
      @(negedge clk);
    end

    // Hold: new data on the bus but in_valid low.
    drive(1'b0, {4{32'hdeadbeef}});
    @(posedge clk);
    #1;
    check_vec("hold_vect", last_exp);
    check_bit("hold_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_vec("hold_vect_2", last_exp);

    // Mid-stream asynchronous reset, asserted away from any clock edge.
    @(negedge clk);
    drive(1'b1, tbl[2].in_v);
    @(posedge clk);
    #2;
    check_bit("pre_reset_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_vec("async_reset_vect", '0);
    check_bit("async_reset_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_bit("reset_held_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, tbl[3].in_v);
    @(posedge clk);
    #1;
    check_vec("first_after_reset", tbl[3].exp_v);
    check_bit("first_after_reset_valid", out_valid, 1'b1);

`ifdef SHIFT_ROWS_INV_EN
    // Inverse mapping undoes the forward AES example.
    @(negedge clk);
    inv = 1'b1;
    drive(1'b1, tbl[0].exp_v);
    @(posedge clk);
    #1;
    check_vec("aes_inv", tbl[0].in_v);
    check_bit("aes_inv_valid", out_valid, 1'b1);
    @(negedge clk);
    drive(1'b1, tbl[2].exp_v);
    @(posedge clk);
    #1;
    check_vec("index_inv", tbl[2].in_v);
    // Switch back to forward in the very next transaction.
    @(negedge clk);
    inv = 1'b0;
    drive(1'b1, tbl[0].in_v);
    @(posedge clk);
    #1;
    check_vec("fwd_after_inv", tbl[0].exp_v);
`endif

    @(negedge clk);
    drive(1'b0, '0);
    @(posedge clk);
    #1;
    check_bit("final_idle_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
